// File: rtl/change_dispenser_if.sv
// Vend-result, solenoid and coin-hopper signals of the change dispenser.
// master = vending core / hopper side, slave = change_dispenser.
interface change_dispenser_if #(
  parameter int ITEM_W  = 3,
  parameter int MONEY_W = 3
);
  logic               vend_valid;
  logic [ITEM_W-1:0]  item;
  logic [MONEY_W-1:0] remaining_money;
  logic               vend_ready;
  logic               item_release;
  logic [ITEM_W-1:0]  item_code;
  logic               coin_req;
  logic               hopper_ack;
  logic [MONEY_W-1:0] coins_left;
  logic               done;
  logic               fault;

  modport master (
    output vend_valid, item, remaining_money, hopper_ack,
    input  vend_ready, item_release, item_code, coin_req, coins_left, done, fault
  );

  modport slave (
    input  vend_valid, item, remaining_money, hopper_ack,
    output vend_ready, item_release, item_code, coin_req, coins_left, done, fault
  );
endinterface

// File: rtl/change_dispenser.sv
// Executes a vend result: strobes the item solenoid, then pays change one coin per hopper req/ack.
// Optional CHANGE_DISPENSER_TIMEOUT_EN adds a hopper ack watchdog with a sticky fault.
module change_dispenser #(
  parameter int ITEM_W         = 3,
  parameter int MONEY_W        = 3,
  parameter int RELEASE_CYCLES = 2,
  parameter int ACK_TIMEOUT    = 15
) (
  input  logic              clk,
  input  logic              rst,
  change_dispenser_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE, RELEASE, PAY_REQ, PAY_WAIT, DONE, FAULT
  } state_e;

  localparam logic [3:0] REL_LAST = 4'(RELEASE_CYCLES - 1);

  state_e             state;
  state_e             state_next;
  logic [ITEM_W-1:0]  item_code_q;
  logic [MONEY_W-1:0] coins_q;
  logic [3:0]         rel_cnt;
  logic               accept;
  logic               timed_out;

  assign accept = (state == IDLE) && bus.vend_valid;

  // NOTE: every register is written with <= so all flops sample the same pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      item_code_q <= '0;
      coins_q     <= '0;
      rel_cnt     <= '0;
    end else begin
      if (accept) begin
        item_code_q <= bus.item;
        coins_q     <= bus.remaining_money;
      end else if (state == DONE) begin
        item_code_q <= '0;
      end
      if (state == PAY_REQ && bus.hopper_ack && coins_q != '0)
        coins_q <= coins_q - 1'b1;
      if (state == RELEASE) rel_cnt <= rel_cnt + 1'b1;
      else                  rel_cnt <= '0;
    end
  end

`ifdef CHANGE_DISPENSER_TIMEOUT_EN
  logic [7:0] wait_cnt;

  // Restarts on every state change, so each request and each ack release gets its own budget.
  always_ff @(posedge clk) begin
    if (rst)                                        wait_cnt <= '0;
    else if (state_next != state)                   wait_cnt <= '0;
    else if (state == PAY_REQ || state == PAY_WAIT) wait_cnt <= wait_cnt + 1'b1;
  end

  assign timed_out = (wait_cnt == 8'(ACK_TIMEOUT - 1));
  assign bus.fault = (state == FAULT);
`else
  assign timed_out = 1'b0;
  assign bus.fault = 1'b0;
`endif

  // NOTE: defaults first so no path through the case leaves a signal unassigned (no latches).
  always_comb begin
    state_next       = state;
    bus.vend_ready   = 1'b0;
    bus.item_release = 1'b0;
    bus.coin_req     = 1'b0;
    bus.done         = 1'b0;
    case (state)
      IDLE: begin
        bus.vend_ready = 1'b1;
        if (bus.vend_valid) begin
          if (bus.item != '0)                 state_next = RELEASE;
          else if (bus.remaining_money != '0) state_next = PAY_REQ;
          else                                state_next = DONE;
        end
      end
      RELEASE: begin
        bus.item_release = 1'b1;
        if (rel_cnt == REL_LAST) state_next = (coins_q != '0) ? PAY_REQ : DONE;
      end
      PAY_REQ: begin
        bus.coin_req = 1'b1;
        if (bus.hopper_ack)  state_next = PAY_WAIT;
        else if (timed_out)  state_next = FAULT;
      end
      PAY_WAIT: begin
        if (!bus.hopper_ack) state_next = (coins_q != '0) ? PAY_REQ : DONE;
        else if (timed_out)  state_next = FAULT;
      end
      DONE: begin
        bus.done   = 1'b1;
        state_next = IDLE;
      end
      FAULT:   state_next = FAULT;
      default: state_next = IDLE;
    endcase
  end

  assign bus.item_code  = item_code_q;
  assign bus.coins_left = coins_q;

endmodule

// File: tb/tb_change_dispenser.sv
// Directed self-checking bench for change_dispenser; a small hopper model answers coin_req.
// Build with +define+CHANGE_DISPENSER_TIMEOUT_EN on both files to exercise the watchdog.
module tb_change_dispenser;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  // Hopper model controls and activity log.
  bit   hopper_en = 1'b1;
  int   ack_delay = 0;
  int   ack_wait  = 0;
  int   n_req, n_rel, n_done;
  logic [2:0] rel_code, done_coins;
  logic [2:0] req_coins[$];
  logic prev_req = 1'b0;

  change_dispenser_if #(.ITEM_W(3), .MONEY_W(3)) bus ();

  change_dispenser #(
    .ITEM_W(3), .MONEY_W(3), .RELEASE_CYCLES(2), .ACK_TIMEOUT(15)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Hopper: raises ack ack_delay cycles after seeing coin_req, holds it until coin_req drops.
  initial begin : hopper
    bus.hopper_ack = 1'b0;
    forever begin
      @(posedge clk); #2;
      if (hopper_en && bus.coin_req && !bus.hopper_ack) begin
        if (ack_wait >= ack_delay) begin
          bus.hopper_ack = 1'b1;
          ack_wait = 0;
        end else begin
          ack_wait++;
        end
      end else if (bus.hopper_ack && !bus.coin_req) begin
        bus.hopper_ack = 1'b0;
      end
    end
  end

  initial begin : monitor
    forever begin
      @(posedge clk); #3;
      if (bus.coin_req && !prev_req) begin
        n_req++;
        req_coins.push_back(bus.coins_left);
      end
      prev_req = bus.coin_req;
      if (bus.item_release) begin
        n_rel++;
        rel_code = bus.item_code;
      end
      if (bus.done) begin
        n_done++;
        done_coins = bus.coins_left;
      end
    end
  end

  task automatic clear_log();
    n_req = 0; n_rel = 0; n_done = 0;
    rel_code = '0; done_coins = '1;
    req_coins.delete();
  endtask

  task automatic cycles(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Presents one vend result for a single edge; returns at the sample point after that edge.
  task automatic vend(input logic [2:0] it, input logic [2:0] money);
    bus.vend_valid      = 1'b1;
    bus.item            = it;
    bus.remaining_money = money;
    @(posedge clk); #1;
    bus.vend_valid      = 1'b0;
    bus.item            = '0;
    bus.remaining_money = '0;
  endtask

  task automatic wait_done(input int max_cycles, input string name);
    bit seen = 1'b0;
    for (int i = 0; i < max_cycles && !seen; i++) begin
      @(posedge clk); #1;
      if (bus.done === 1'b1) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL %s_done_timeout: no done within %0d cycles", name, max_cycles);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cycles(2);
    checks++;
    if ({bus.vend_ready, bus.item_release, bus.item_code, bus.coin_req,
         bus.coins_left, bus.done, bus.fault} !== {1'b1, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_outputs: ready=%b rel=%b code=%0d req=%b left=%0d done=%b fault=%b, expected 1 0 0 0 0 0 0",
               bus.vend_ready, bus.item_release, bus.item_code, bus.coin_req,
               bus.coins_left, bus.done, bus.fault);
    end
    rst = 1'b0;
    cycles(1);
  endtask

  task automatic test_item_and_change();
    clear_log();
    ack_delay = 1;
    vend(3'd3, 3'd2);
    checks++;
    if ({bus.vend_ready, bus.item_release, bus.item_code, bus.coins_left} !== {1'b0, 1'b1, 3'd3, 3'd2}) begin
      errors++;
      $display("FAIL item_accept: ready=%b rel=%b code=%0d left=%0d, expected 0 1 3 2",
               bus.vend_ready, bus.item_release, bus.item_code, bus.coins_left);
    end
    cycles(2);
    checks++;
    if ({bus.item_release, bus.coin_req} !== 2'b01) begin
      errors++;
      $display("FAIL item_release_len: rel=%b req=%b two cycles after accept, expected 0 1",
               bus.item_release, bus.coin_req);
    end
    wait_done(40, "item");
    checks++;
    if (bus.coins_left !== 3'd0) begin
      errors++;
      $display("FAIL item_left_at_done: got %0d expected 0", bus.coins_left);
    end
    cycles(1);
    checks++;
    if ({bus.vend_ready, bus.done, bus.item_code} !== {1'b1, 1'b0, 3'd0}) begin
      errors++;
      $display("FAIL item_back_idle: ready=%b done=%b code=%0d, expected 1 0 0",
               bus.vend_ready, bus.done, bus.item_code);
    end
    cycles(3);
    checks++;
    if (n_rel !== 2 || rel_code !== 3'd3) begin
      errors++;
      $display("FAIL item_release_cycles: cycles=%0d code=%0d, expected 2 3", n_rel, rel_code);
    end
    checks++;
    if (n_req !== 2 || n_done !== 1) begin
      errors++;
      $display("FAIL item_counts: reqs=%0d dones=%0d, expected 2 1", n_req, n_done);
    end
    for (int i = 0; i < 2 && i < req_coins.size(); i++) begin
      checks++;
      if (req_coins[i] !== 3'(2 - i)) begin
        errors++;
        $display("FAIL item_coin_seq[%0d]: coins_left=%0d expected %0d", i, req_coins[i], 2 - i);
      end
    end
  endtask

  task automatic test_empty_vend();
    clear_log();
    vend(3'd0, 3'd0);
    checks++;
    if ({bus.done, bus.item_release, bus.coin_req, bus.vend_ready} !== 4'b1000) begin
      errors++;
      $display("FAIL empty_done: done=%b rel=%b req=%b ready=%b right after accept, expected 1 0 0 0",
               bus.done, bus.item_release, bus.coin_req, bus.vend_ready);
    end
    cycles(1);
    checks++;
    if ({bus.done, bus.vend_ready} !== 2'b01) begin
      errors++;
      $display("FAIL empty_pulse_width: done=%b ready=%b, expected 0 1", bus.done, bus.vend_ready);
    end
    cycles(2);
    checks++;
    if (n_req !== 0 || n_rel !== 0 || n_done !== 1) begin
      errors++;
      $display("FAIL empty_activity: reqs=%0d rel=%0d dones=%0d, expected 0 0 1", n_req, n_rel, n_done);
    end
  endtask

  task automatic test_max_change();
    clear_log();
    ack_delay = 4;
    vend(3'd5, 3'd7);
    wait_done(150, "max");
    cycles(10);
    checks++;
    if (n_req !== 7 || done_coins !== 3'd0 || n_done !== 1) begin
      errors++;
      $display("FAIL max_counts: reqs=%0d left_at_done=%0d dones=%0d, expected 7 0 1",
               n_req, done_coins, n_done);
    end
    for (int i = 0; i < 7 && i < req_coins.size(); i++) begin
      checks++;
      if (req_coins[i] !== 3'(7 - i)) begin
        errors++;
        $display("FAIL max_coin_seq[%0d]: coins_left=%0d expected %0d", i, req_coins[i], 7 - i);
      end
    end
  endtask

  task automatic test_ignore_during_payout();
    bit got_req = 1'b0;
    clear_log();
    ack_delay = 2;
    vend(3'd2, 3'd3);
    for (int i = 0; i < 10 && !got_req; i++) begin
      if (bus.coin_req === 1'b1) got_req = 1'b1;
      else cycles(1);
    end
    checks++;
    if (!got_req) begin
      errors++;
      $display("FAIL ignore_first_req: coin_req never rose within 10 cycles");
    end
    vend(3'd1, 3'd3);
    checks++;
    if ({bus.coins_left, bus.vend_ready, bus.item_code} !== {3'd3, 1'b0, 3'd2}) begin
      errors++;
      $display("FAIL ignore_second_vend: left=%0d ready=%b code=%0d, expected 3 0 2",
               bus.coins_left, bus.vend_ready, bus.item_code);
    end
    wait_done(60, "ignore");
    cycles(4);
    checks++;
    if (n_req !== 3 || n_rel !== 2 || n_done !== 1 || bus.item_code !== 3'd0) begin
      errors++;
      $display("FAIL ignore_counts: reqs=%0d rel=%0d dones=%0d code=%0d, expected 3 2 1 0",
               n_req, n_rel, n_done, bus.item_code);
    end
  endtask

  task automatic test_reset_mid_payout();
    bit at_four = 1'b0;
    clear_log();
    ack_delay = 0;
    vend(3'd0, 3'd6);
    for (int i = 0; i < 20 && !at_four; i++) begin
      if (bus.coin_req === 1'b1 && bus.coins_left === 3'd4) at_four = 1'b1;
      else cycles(1);
    end
    checks++;
    if (!at_four) begin
      errors++;
      $display("FAIL midrst_reach_four: coins_left=4 with coin_req never seen");
    end
    rst = 1'b1;
    cycles(1);
    rst = 1'b0;
    checks++;
    if ({bus.vend_ready, bus.item_release, bus.item_code, bus.coin_req,
         bus.coins_left, bus.done, bus.fault} !== {1'b1, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL midrst_outputs: ready=%b rel=%b code=%0d req=%b left=%0d done=%b fault=%b, expected 1 0 0 0 0 0 0",
               bus.vend_ready, bus.item_release, bus.item_code, bus.coin_req,
               bus.coins_left, bus.done, bus.fault);
    end
    cycles(4);
    checks++;
    if (n_done !== 0 || bus.vend_ready !== 1'b1) begin
      errors++;
      $display("FAIL midrst_no_done: dones=%0d ready=%b, expected 0 1", n_done, bus.vend_ready);
    end
    clear_log();
    vend(3'd4, 3'd1);
    wait_done(30, "midrst_fresh");
    cycles(3);
    checks++;
    if (n_req !== 1 || n_rel !== 2 || rel_code !== 3'd4 || n_done !== 1) begin
      errors++;
      $display("FAIL midrst_fresh: reqs=%0d rel=%0d code=%0d dones=%0d, expected 1 2 4 1",
               n_req, n_rel, rel_code, n_done);
    end
  endtask

`ifdef CHANGE_DISPENSER_TIMEOUT_EN
  task automatic test_timeout();
    clear_log();
    hopper_en = 1'b0;
    vend(3'd0, 3'd1);
    cycles(14);
    checks++;
    if ({bus.coin_req, bus.fault} !== 2'b10) begin
      errors++;
      $display("FAIL timeout_15th_cycle: req=%b fault=%b, expected 1 0", bus.coin_req, bus.fault);
    end
    cycles(1);
    checks++;
    if ({bus.coin_req, bus.fault, bus.vend_ready, bus.coins_left} !== {1'b0, 1'b1, 1'b0, 3'd1}) begin
      errors++;
      $display("FAIL timeout_fault: req=%b fault=%b ready=%b left=%0d, expected 0 1 0 1",
               bus.coin_req, bus.fault, bus.vend_ready, bus.coins_left);
    end
    hopper_en = 1'b1;
    vend(3'd2, 3'd2);
    cycles(20);
    checks++;
    if ({bus.fault, bus.coin_req, bus.item_release, bus.coins_left} !== {1'b1, 1'b0, 1'b0, 3'd1}) begin
      errors++;
      $display("FAIL timeout_sticky: fault=%b req=%b rel=%b left=%0d, expected 1 0 0 1",
               bus.fault, bus.coin_req, bus.item_release, bus.coins_left);
    end
    rst = 1'b1;
    cycles(1);
    rst = 1'b0;
    checks++;
    if ({bus.fault, bus.vend_ready} !== 2'b01) begin
      errors++;
      $display("FAIL timeout_rst_clears: fault=%b ready=%b, expected 0 1", bus.fault, bus.vend_ready);
    end
  endtask
`else
  task automatic test_hopper_stall();
    clear_log();
    hopper_en = 1'b0;
    vend(3'd0, 3'd1);
    cycles(40);
    checks++;
    if ({bus.coin_req, bus.fault, bus.coins_left, bus.vend_ready} !== {1'b1, 1'b0, 3'd1, 1'b0}) begin
      errors++;
      $display("FAIL stall_waits: req=%b fault=%b left=%0d ready=%b, expected 1 0 1 0",
               bus.coin_req, bus.fault, bus.coins_left, bus.vend_ready);
    end
    hopper_en = 1'b1;
    ack_delay = 0;
    wait_done(10, "stall_resume");
    checks++;
    if (bus.coins_left !== 3'd0) begin
      errors++;
      $display("FAIL stall_resume_left: got %0d expected 0", bus.coins_left);
    end
    cycles(1);
  endtask
`endif

  initial begin : main
    bus.vend_valid      = 1'b0;
    bus.item            = '0;
    bus.remaining_money = '0;
    rst                 = 1'b1;
    clear_log();
    test_reset();
    test_item_and_change();
    test_empty_vend();
    test_max_change();
    test_ignore_during_payout();
    test_reset_mid_payout();
`ifdef CHANGE_DISPENSER_TIMEOUT_EN
    test_timeout();
`else
    test_hopper_stall();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
